// File: rtl/mem_stage_initiator_if.sv
// Data-memory request/response bus between the memory stage and data memory.
// Requests use valid/ready; read data returns on a valid-only channel.
interface mem_stage_initiator_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_rdata;

  modport master (
    output mem_req_valid,
    output mem_req_we,
    output mem_req_addr,
    output mem_req_wdata,
    input  mem_req_ready,
    input  mem_rsp_valid,
    input  mem_rsp_rdata
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_we,
    input  mem_req_addr,
    input  mem_req_wdata,
    output mem_req_ready,
    output mem_rsp_valid,
    output mem_rsp_rdata
  );
endinterface

// File: rtl/mem_stage_initiator.sv
// Y86 memory-stage initiator: issues at most one data-memory access per
// instruction and returns valM to write-back with a one-cycle pulse.
module mem_stage_initiator #(
  parameter int MEM_WORDS      = 128,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic [63:0] valA,
  input  logic [63:0] valE,
  input  logic [63:0] valP,
  mem_stage_initiator_if.master mem,
  output logic        out_valid,
  output logic [63:0] valM,
  output logic        dmem_error
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_e;

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [63:0] ADDR_LIMIT = 64'(MEM_WORDS);

  state_e        state_q;
  logic          in_ready_q;
  logic          req_valid_q;
  logic          req_we_q;
  logic [63:0]   req_addr_q;
  logic [63:0]   req_wdata_q;
  logic          out_valid_q;
  logic [63:0]   valM_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;

  logic          acc_d;
  logic          we_d;
  logic [63:0]   addr_d;
  logic [63:0]   wdata_d;

  always_comb begin
    acc_d   = 1'b0;
    we_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    unique case (1'b1)
      (icode == 4'h4) || (icode == 4'hA): begin
        acc_d   = 1'b1;
        we_d    = 1'b1;
        addr_d  = valE;
        wdata_d = valA;
      end
      (icode == 4'h8): begin
        acc_d   = 1'b1;
        we_d    = 1'b1;
        addr_d  = valE;
        wdata_d = valP;
      end
      (icode == 4'h5): begin
        acc_d  = 1'b1;
        addr_d = valE;
      end
      (icode == 4'h9) || (icode == 4'hB): begin
        acc_d  = 1'b1;
        addr_d = valA;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      out_valid_q <= 1'b0;
      valM_q      <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            valM_q     <= '0;
            err_q      <= 1'b0;
            if (!acc_d) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else if (addr_d >= ADDR_LIMIT) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              err_q       <= 1'b1;
            end else begin
              state_q     <= REQ;
              req_valid_q <= 1'b1;
              req_we_q    <= we_d;
              req_addr_q  <= addr_d;
              req_wdata_q <= wdata_d;
            end
          end
        end
        REQ: begin
          // writes retire at the handshake; there is no write ack
          if (mem.mem_req_ready) begin
            req_valid_q <= 1'b0;
            if (req_we_q) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= WAIT;
              cnt_q   <= '0;
            end
          end
        end
        WAIT: begin
          if (mem.mem_rsp_valid) begin
            valM_q      <= mem.mem_rsp_rdata;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            valM_q      <= '0;
            err_q       <= 1'b1;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready          = in_ready_q;
  assign mem.mem_req_valid = req_valid_q;
  assign mem.mem_req_we    = req_we_q;
  assign mem.mem_req_addr  = req_addr_q;
  assign mem.mem_req_wdata = req_wdata_q;
  assign out_valid         = out_valid_q;
  assign valM              = valM_q;
  assign dmem_error        = err_q;

endmodule

// File: tb/tb_mem_stage_initiator.sv
// Directed bench for mem_stage_initiator with hand-computed expectations.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_mem_stage_initiator;
  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode;
  logic [63:0] valA;
  logic [63:0] valE;
  logic [63:0] valP;
  logic        out_valid;
  logic [63:0] valM;
  logic        dmem_error;

  int errs;
  int checks;

  mem_stage_initiator_if mif ();

  mem_stage_initiator #(
    .MEM_WORDS(128),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .icode(icode),
    .valA(valA),
    .valE(valE),
    .valP(valP),
    .mem(mif.master),
    .out_valid(out_valid),
    .valM(valM),
    .dmem_error(dmem_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    errs = 0;
    checks = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    icode = 4'h0;
    valA = '0;
    valE = '0;
    valP = '0;
    mif.mem_req_ready = 1'b0;
    mif.mem_rsp_valid = 1'b0;
    mif.mem_rsp_rdata = '0;
    tick();
    tick();
    reset = 1'b0;

    // reset state
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_req_valid", 64'(mif.mem_req_valid), 64'd0);
    chk("rst_req_we", 64'(mif.mem_req_we), 64'd0);
    chk("rst_req_addr", mif.mem_req_addr, 64'd0);
    chk("rst_req_wdata", mif.mem_req_wdata, 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_valM", valM, 64'd0);
    chk("rst_err", 64'(dmem_error), 64'd0);

    // 1: irmovq, no access, result at T+1
    in_valid = 1'b1;
    icode = 4'h3;
    valE = 64'd42;
    tick();
    in_valid = 1'b0;
    chk("t1_out_valid", 64'(out_valid), 64'd1);
    chk("t1_valM", valM, 64'd0);
    chk("t1_err", 64'(dmem_error), 64'd0);
    chk("t1_no_req", 64'(mif.mem_req_valid), 64'd0);
    chk("t1_in_ready_busy", 64'(in_ready), 64'd0);
    tick();
    chk("t1_pulse_end", 64'(out_valid), 64'd0);
    chk("t1_in_ready_back", 64'(in_ready), 64'd1);

    // 2: rmmovq write, ready immediately, result at T+2
    mif.mem_req_ready = 1'b1;
    in_valid = 1'b1;
    icode = 4'h4;
    valE = 64'd5;
    valA = 64'h0F;
    tick();
    in_valid = 1'b0;
    chk("t2_req_valid", 64'(mif.mem_req_valid), 64'd1);
    chk("t2_req_we", 64'(mif.mem_req_we), 64'd1);
    chk("t2_req_addr", mif.mem_req_addr, 64'd5);
    chk("t2_req_wdata", mif.mem_req_wdata, 64'h0F);
    chk("t2_out_early", 64'(out_valid), 64'd0);
    tick();
    chk("t2_out_valid", 64'(out_valid), 64'd1);
    chk("t2_req_drop", 64'(mif.mem_req_valid), 64'd0);
    chk("t2_err", 64'(dmem_error), 64'd0);
    tick();

    // 3: mrmovq read with 3 stall cycles; responses in REQ are ignored
    mif.mem_req_ready = 1'b0;
    in_valid = 1'b1;
    icode = 4'h5;
    valE = 64'd5;
    valA = 64'h99;
    tick();
    in_valid = 1'b0;
    mif.mem_rsp_valid = 1'b1;
    mif.mem_rsp_rdata = 64'hDEAD;
    for (int i = 0; i < 3; i++) begin
      chk("t3_stall_valid", 64'(mif.mem_req_valid), 64'd1);
      chk("t3_stall_addr", mif.mem_req_addr, 64'd5);
      chk("t3_stall_we", 64'(mif.mem_req_we), 64'd0);
      chk("t3_stall_out", 64'(out_valid), 64'd0);
      tick();
    end
    mif.mem_rsp_valid = 1'b0;
    mif.mem_req_ready = 1'b1;
    chk("t3_hs_valid", 64'(mif.mem_req_valid), 64'd1);
    tick();
    mif.mem_req_ready = 1'b0;
    chk("t3_wait_req_low", 64'(mif.mem_req_valid), 64'd0);
    chk("t3_wait_out", 64'(out_valid), 64'd0);
    tick();
    mif.mem_rsp_valid = 1'b1;
    mif.mem_rsp_rdata = 64'h0F;
    tick();
    mif.mem_rsp_valid = 1'b0;
    chk("t3_out_valid", 64'(out_valid), 64'd1);
    chk("t3_valM", valM, 64'h0F);
    chk("t3_err", 64'(dmem_error), 64'd0);
    tick();
    chk("t3_valM_held", valM, 64'h0F);

    // 4: call with out-of-range address
    mif.mem_req_ready = 1'b1;
    in_valid = 1'b1;
    icode = 4'h8;
    valE = 64'd200;
    valP = 64'h77;
    tick();
    in_valid = 1'b0;
    chk("t4_out_valid", 64'(out_valid), 64'd1);
    chk("t4_err", 64'(dmem_error), 64'd1);
    chk("t4_valM", valM, 64'd0);
    chk("t4_no_req", 64'(mif.mem_req_valid), 64'd0);
    tick();

    // boundary: address 128 is out of range, 127 is legal
    in_valid = 1'b1;
    icode = 4'h5;
    valE = 64'd128;
    tick();
    in_valid = 1'b0;
    chk("b128_err", 64'(dmem_error), 64'd1);
    chk("b128_no_req", 64'(mif.mem_req_valid), 64'd0);
    tick();
    in_valid = 1'b1;
    icode = 4'hA;
    valE = 64'd127;
    valA = 64'h33;
    tick();
    in_valid = 1'b0;
    chk("b127_err_clr", 64'(dmem_error), 64'd0);
    chk("b127_req", 64'(mif.mem_req_valid), 64'd1);
    chk("b127_addr", mif.mem_req_addr, 64'd127);
    tick();
    chk("b127_out", 64'(out_valid), 64'd1);
    tick();

    // high address bits set must also be rejected
    in_valid = 1'b1;
    icode = 4'h5;
    valE = 64'h8000_0000_0000_0005;
    tick();
    in_valid = 1'b0;
    chk("bhi_err", 64'(dmem_error), 64'd1);
    chk("bhi_no_req", 64'(mif.mem_req_valid), 64'd0);
    tick();

    // 5: popq timeout after 15 WAIT cycles, then a late response
    in_valid = 1'b1;
    icode = 4'hB;
    valA = 64'd7;
    tick();
    in_valid = 1'b0;
    chk("t5_req_addr", mif.mem_req_addr, 64'd7);
    chk("t5_req_we", 64'(mif.mem_req_we), 64'd0);
    tick();
    for (int i = 0; i < 15; i++) begin
      chk("t5_wait_out", 64'(out_valid), 64'd0);
      tick();
    end
    chk("t5_out_valid", 64'(out_valid), 64'd1);
    chk("t5_err", 64'(dmem_error), 64'd1);
    chk("t5_valM", valM, 64'd0);
    tick();
    mif.mem_rsp_valid = 1'b1;
    mif.mem_rsp_rdata = 64'h55;
    tick();
    mif.mem_rsp_valid = 1'b0;
    chk("t5_late_out", 64'(out_valid), 64'd0);
    chk("t5_late_valM", valM, 64'd0);
    chk("t5_late_ready", 64'(in_ready), 64'd1);

    // 6: reset during pushq REQ, then a ret completes
    mif.mem_req_ready = 1'b0;
    in_valid = 1'b1;
    icode = 4'hA;
    valE = 64'd9;
    valA = 64'h3;
    tick();
    in_valid = 1'b0;
    chk("t6_req_valid", 64'(mif.mem_req_valid), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rst_req", 64'(mif.mem_req_valid), 64'd0);
    chk("t6_rst_out", 64'(out_valid), 64'd0);
    chk("t6_rst_ready", 64'(in_ready), 64'd1);
    chk("t6_rst_addr", mif.mem_req_addr, 64'd0);
    chk("t6_rst_err", 64'(dmem_error), 64'd0);
    tick();
    chk("t6_no_out", 64'(out_valid), 64'd0);
    mif.mem_req_ready = 1'b1;
    in_valid = 1'b1;
    icode = 4'h9;
    valA = 64'd7;
    tick();
    in_valid = 1'b0;
    chk("t6_ret_addr", mif.mem_req_addr, 64'd7);
    chk("t6_ret_we", 64'(mif.mem_req_we), 64'd0);
    tick();
    mif.mem_rsp_valid = 1'b1;
    mif.mem_rsp_rdata = 64'h1234_5678_9ABC_DEF0;
    tick();
    mif.mem_rsp_valid = 1'b0;
    chk("t6_out_valid", 64'(out_valid), 64'd1);
    chk("t6_valM", valM, 64'h1234_5678_9ABC_DEF0);
    chk("t6_err", 64'(dmem_error), 64'd0);
    tick();
    chk("t6_idle", 64'(in_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
